hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, range 1..15: bubbles inserted per load-use hazard.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports addressRsInput, addressRtInput  input  5 each  source register fields of the instruction in ID.
REQ-006 SHALL have port usesRtInput  input  1  ID instruction reads rt; instrValidInput  input  1  ID holds a valid instruction.
REQ-007 SHALL have ports exMemReadInput  input  1, exRegWriteInput  input  1, exWriteRegisterInput  input  5  describing the instruction in EX.
REQ-008 SHALL have port branchTakenInput  input  1  branch resolved taken in EX; jumpInput  input  1  jump decoded in ID.
REQ-009 SHALL have outputs pcWriteOutput, ifIdWriteOutput, ifIdFlushOutput, idExFlushOutput  output  1 each.
REQ-010 SHALL have outputs stateOutput  output  2  current FSM state, and stallCountOutput  output  COUNT_WIDTH  total stall cycles.

Function
REQ-011 SHALL compute hazard = instrValidInput & exMemReadInput & exRegWriteInput & (exWriteRegisterInput != 0) & ((exWriteRegisterInput == addressRsInput) | (usesRtInput & (exWriteRegisterInput == addressRtInput))).
REQ-012 SHALL implement states RUN=0, STALL=1, FLUSH=2; encoding 3 is illegal and returns to RUN on the next edge.
REQ-013 SHALL drive pcWriteOutput=1, ifIdWriteOutput=1, both flushes=0 in RUN when no event is present.
REQ-014 SHALL assert the stall pattern (pcWriteOutput=0, ifIdWriteOutput=0, idExFlushOutput=1) in the same cycle hazard rises in RUN, with zero-cycle latency via the combinational path.
REQ-015 SHALL, on a RUN hazard with LOAD_STALL_CYCLES>1, load the timer with LOAD_STALL_CYCLES-1 and enter STALL; with LOAD_STALL_CYCLES=1, remain in RUN.
REQ-016 SHALL hold the stall pattern throughout STALL, decrement the timer each cycle, and return to RUN on the edge where the timer is 1.
REQ-017 SHALL, on branchTakenInput=1 in any state, assert ifIdFlushOutput=1 and idExFlushOutput=1 with pcWriteOutput=1, abort any stall, clear the timer, and enter FLUSH.
REQ-018 SHALL, in FLUSH, drive the RUN pattern with ifIdFlushOutput=1 for exactly one cycle, then return to RUN.
REQ-019 SHALL, on jumpInput=1 in RUN with no hazard, assert ifIdFlushOutput=1 only, for one cycle, without changing state.
REQ-020 SHALL prioritise branchTakenInput over hazard, and hazard over jumpInput; a jump coinciding with a hazard is not flushed until the stall completes.
REQ-021 SHALL ignore jumpInput and hazard while in STALL; the held instruction is re-evaluated on return to RUN.

Reset
REQ-022 SHALL, while reset=0, force state RUN, timer 0, and stallCountOutput 0 asynchronously.
REQ-023 SHALL, while reset=0, force pcWriteOutput=1, ifIdWriteOutput=1, ifIdFlushOutput=0, and idExFlushOutput=0 regardless of inputs.
REQ-024 SHALL abandon a stall or flush on reset assertion mid-operation and resume in RUN on the first edge after release.

Configuration
REQ-025 SHALL, with HAZARD_STALL_COUNTER_EN defined, increment stallCountOutput by 1 on every cycle with pcWriteOutput=0, saturating at all-ones.
REQ-026 SHALL, without HAZARD_STALL_COUNTER_EN, tie stallCountOutput to 0 and instantiate no counter register.

Structure
REQ-027 SHALL take the state enum hazardState_t and the constant REG_ZERO=5'd0 from the shared package pipeline_pkg.
REQ-028 SHALL place the down-counter in one sub-module stall_timer (load, decrement, and terminal-count outputs).

Verification
REQ-029 SHALL cover: EX lw to $8, ID add rs=$8, LOAD_STALL_CYCLES=1 -> pcWriteOutput=0 and idExFlushOutput=1 for exactly 1 cycle; state stays RUN.
REQ-030 SHALL cover: same stimulus with LOAD_STALL_CYCLES=3 -> 3 stall cycles, stateOutput sequence 0,1,1,0; stallCountOutput=3.
REQ-031 SHALL cover: EX lw to $0 matching rs=$0 -> no stall; lw to $9 with rt=$9 and usesRtInput=0 -> no stall.
REQ-032 SHALL cover: branchTakenInput=1 in the 2nd cycle of a 3-cycle stall -> both flushes=1, pcWriteOutput=1, FLUSH for 1 cycle, then RUN.
REQ-033 SHALL cover: jumpInput with a simultaneous hazard -> stall first, then ifIdFlushOutput=1 in the first RUN cycle.
REQ-034 SHALL cover: reset=0 asserted mid-STALL -> outputs immediately at reset values and stallCountOutput=0, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM state encoding and architectural constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazardState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned TIMER_WIDTH = 4;

endpackage

// File: rtl/stall_timer.sv
// Load/decrement down-counter that paces multi-cycle load-use stalls.
module stall_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  input  logic             dec,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign terminal = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall / branch-jump flush controller for the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned COUNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             addressRsInput,
  input  logic [4:0]             addressRtInput,
  input  logic                   usesRtInput,
  input  logic                   instrValidInput,
  input  logic                   exMemReadInput,
  input  logic                   exRegWriteInput,
  input  logic [4:0]             exWriteRegisterInput,
  input  logic                   branchTakenInput,
  input  logic                   jumpInput,
  output logic                   pcWriteOutput,
  output logic                   ifIdWriteOutput,
  output logic                   ifIdFlushOutput,
  output logic                   idExFlushOutput,
  output logic [1:0]             stateOutput,
  output logic [COUNT_WIDTH-1:0] stallCountOutput
);

  localparam logic                   MULTI_CYCLE = (LOAD_STALL_CYCLES > 1);
  localparam logic [TIMER_WIDTH-1:0] LOAD_VALUE  = TIMER_WIDTH'(LOAD_STALL_CYCLES - 1);

  hazardState_t state, next_state;
  logic hazard;
  logic timer_load, timer_clear, timer_dec, timer_terminal;

  assign hazard = instrValidInput & exMemReadInput & exRegWriteInput &
                  (exWriteRegisterInput != REG_ZERO) &
                  ((exWriteRegisterInput == addressRsInput) |
                   (usesRtInput & (exWriteRegisterInput == addressRtInput)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = RUN;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    timer_dec   = 1'b0;
    if (branchTakenInput) begin
      next_state  = FLUSH;
      timer_clear = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hazard && MULTI_CYCLE) begin
            next_state = STALL;
            timer_load = 1'b1;
          end
        end
        STALL: begin
          timer_dec  = 1'b1;
          next_state = timer_terminal ? RUN : STALL;
        end
        FLUSH:   next_state = RUN;
        default: next_state = RUN;
      endcase
    end
  end

  // Outputs are gated by reset so they take safe values before any clock edge.
  always_comb begin
    pcWriteOutput   = 1'b1;
    ifIdWriteOutput = 1'b1;
    ifIdFlushOutput = 1'b0;
    idExFlushOutput = 1'b0;
    if (reset) begin
      if (branchTakenInput) begin
        ifIdFlushOutput = 1'b1;
        idExFlushOutput = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              pcWriteOutput   = 1'b0;
              ifIdWriteOutput = 1'b0;
              idExFlushOutput = 1'b1;
            end else if (jumpInput) begin
              ifIdFlushOutput = 1'b1;
            end
          end
          STALL: begin
            pcWriteOutput   = 1'b0;
            ifIdWriteOutput = 1'b0;
            idExFlushOutput = 1'b1;
          end
          FLUSH:   ifIdFlushOutput = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign stateOutput = state;

  stall_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_stall_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (LOAD_VALUE),
    .clear      (timer_clear),
    .dec        (timer_dec),
    .terminal   (timer_terminal)
  );

`ifdef HAZARD_STALL_COUNTER_EN
  logic [COUNT_WIDTH-1:0] stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!pcWriteOutput && (stall_count != '1)) begin
      stall_count <= stall_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign stallCountOutput = stall_count;
`else
  assign stallCountOutput = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: two controllers (1-cycle and 3-cycle load stall) on shared stimulus.
module tb_hazard_controller;

`ifdef HAZARD_STALL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs, rt, ex_wr;
  logic       uses_rt, valid, ex_mr, ex_rw, branch, jump;

  logic        pc1, ifw1, iff1, ief1;
  logic [1:0]  st1;
  logic [31:0] cnt1;
  logic        pc3, ifw3, iff3, ief3;
  logic [1:0]  st3;
  logic [31:0] cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .COUNT_WIDTH(32)) u1 (
    .clk(clk), .reset(reset),
    .addressRsInput(rs), .addressRtInput(rt), .usesRtInput(uses_rt),
    .instrValidInput(valid), .exMemReadInput(ex_mr), .exRegWriteInput(ex_rw),
    .exWriteRegisterInput(ex_wr), .branchTakenInput(branch), .jumpInput(jump),
    .pcWriteOutput(pc1), .ifIdWriteOutput(ifw1), .ifIdFlushOutput(iff1),
    .idExFlushOutput(ief1), .stateOutput(st1), .stallCountOutput(cnt1)
  );

  hazard_controller #(.LOAD_STALL_CYCLES(3), .COUNT_WIDTH(32)) u3 (
    .clk(clk), .reset(reset),
    .addressRsInput(rs), .addressRtInput(rt), .usesRtInput(uses_rt),
    .instrValidInput(valid), .exMemReadInput(ex_mr), .exRegWriteInput(ex_rw),
    .exWriteRegisterInput(ex_wr), .branchTakenInput(branch), .jumpInput(jump),
    .pcWriteOutput(pc3), .ifIdWriteOutput(ifw3), .ifIdFlushOutput(iff3),
    .idExFlushOutput(ief3), .stateOutput(st3), .stallCountOutput(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rs = 5'd0; rt = 5'd0; ex_wr = 5'd0;
    uses_rt = 1'b0; valid = 1'b0; ex_mr = 1'b0; ex_rw = 1'b0;
    branch = 1'b0; jump = 1'b0;
  endtask

  // EX: lw $8 ; ID: add rs=$8 rt=$3
  task automatic load_use();
    valid = 1'b1; rs = 5'd8; rt = 5'd3; uses_rt = 1'b1;
    ex_mr = 1'b1; ex_rw = 1'b1; ex_wr = 5'd8;
  endtask

  task automatic ex_bubble();
    ex_mr = 1'b0; ex_rw = 1'b0; ex_wr = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    // Reset with hazard and branch present: outputs must still be the safe pattern
    load_use();
    branch = 1'b1;
    #2;
    check("rst_pc",    pc3,  1'b1);
    check("rst_ifw",   ifw3, 1'b1);
    check("rst_iff",   iff3, 1'b0);
    check("rst_ief",   ief3, 1'b0);
    check("rst_state", st3,  2'd0);
    check("rst_cnt",   cnt3, 32'd0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;

    // Load-use, 1 and 3 stall cycles
    @(negedge clk);
    load_use();
    #1;
    check("lu1_c0_pc",  pc1,  1'b0);
    check("lu1_c0_ief", ief1, 1'b1);
    check("lu1_c0_ifw", ifw1, 1'b0);
    check("lu1_c0_st",  st1,  2'd0);
    check("lu3_c0_pc",  pc3,  1'b0);
    check("lu3_c0_st",  st3,  2'd0);
    @(negedge clk);
    ex_bubble();
    #1;
    check("lu1_c1_pc",  pc1,  1'b1);
    check("lu1_c1_ief", ief1, 1'b0);
    check("lu1_c1_st",  st1,  2'd0);
    check("lu1_cnt",    cnt1, CNT_EN ? 32'd1 : 32'd0);
    check("lu3_c1_st",  st3,  2'd1);
    check("lu3_c1_pc",  pc3,  1'b0);
    check("lu3_c1_ief", ief3, 1'b1);
    @(negedge clk);
    #1;
    check("lu3_c2_st",  st3,  2'd1);
    check("lu3_c2_pc",  pc3,  1'b0);
    @(negedge clk);
    #1;
    check("lu3_c3_st",  st3,  2'd0);
    check("lu3_c3_pc",  pc3,  1'b1);
    check("lu3_c3_ief", ief3, 1'b0);
    check("lu3_cnt",    cnt3, CNT_EN ? 32'd3 : 32'd0);

    // No hazard: write to $0, and rt match with usesRt low
    do_reset();
    @(negedge clk);
    valid = 1'b1; rs = 5'd0; rt = 5'd5; uses_rt = 1'b1;
    ex_mr = 1'b1; ex_rw = 1'b1; ex_wr = 5'd0;
    #1;
    check("zero_pc1",  pc1,  1'b1);
    check("zero_pc3",  pc3,  1'b1);
    check("zero_ief3", ief3, 1'b0);
    rs = 5'd4; rt = 5'd9; uses_rt = 1'b0; ex_wr = 5'd9;
    #1;
    check("nort_pc1",  pc1,  1'b1);
    check("nort_pc3",  pc3,  1'b1);
    uses_rt = 1'b1;
    #1;
    check("rt_pc3",    pc3,  1'b0);
    check("rt_ief3",   ief3, 1'b1);

    // Branch in the second cycle of a 3-cycle stall
    do_reset();
    @(negedge clk);
    load_use();
    @(negedge clk);
    ex_bubble();
    branch = 1'b1;
    #1;
    check("br_c1_st",  st3,  2'd1);
    check("br_c1_pc",  pc3,  1'b1);
    check("br_c1_ifw", ifw3, 1'b1);
    check("br_c1_iff", iff3, 1'b1);
    check("br_c1_ief", ief3, 1'b1);
    @(negedge clk);
    branch = 1'b0;
    #1;
    check("br_c2_st",  st3,  2'd2);
    check("br_c2_pc",  pc3,  1'b1);
    check("br_c2_iff", iff3, 1'b1);
    check("br_c2_ief", ief3, 1'b0);
    @(negedge clk);
    #1;
    check("br_c3_st",  st3,  2'd0);
    check("br_c3_iff", iff3, 1'b0);
    check("br_c3_pc",  pc3,  1'b1);

    // Jump coinciding with hazard: flush only after the stall
    do_reset();
    @(negedge clk);
    load_use();
    jump = 1'b1;
    #1;
    check("jh_c0_pc",  pc3,  1'b0);
    check("jh_c0_iff", iff3, 1'b0);
    @(negedge clk);
    ex_bubble();
    #1;
    check("jh_c1_st",  st3,  2'd1);
    check("jh_c1_iff", iff3, 1'b0);
    @(negedge clk);
    #1;
    check("jh_c2_iff", iff3, 1'b0);
    @(negedge clk);
    #1;
    check("jh_c3_st",  st3,  2'd0);
    check("jh_c3_iff", iff3, 1'b1);
    check("jh_c3_pc",  pc3,  1'b1);
    check("jh_c3_ief", ief3, 1'b0);
    @(negedge clk);
    jump = 1'b0;
    #1;
    check("jh_c4_iff", iff3, 1'b0);

    // Asynchronous reset in the middle of STALL
    do_reset();
    @(negedge clk);
    load_use();
    @(negedge clk);
    ex_bubble();
    #1;
    check("ar_pre_st", st3, 2'd1);
    check("ar_pre_pc", pc3, 1'b0);
    #2;
    reset  = 1'b0;
    branch = 1'b1;
    #1;
    check("ar_pc",  pc3,  1'b1);
    check("ar_ifw", ifw3, 1'b1);
    check("ar_iff", iff3, 1'b0);
    check("ar_ief", ief3, 1'b0);
    check("ar_st",  st3,  2'd0);
    check("ar_cnt", cnt3, 32'd0);
    @(negedge clk);
    branch = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    #1;
    check("ar_post_st", st3, 2'd0);
    check("ar_post_pc", pc3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
